// File: rtl/sparse_pe_mac.sv
// Sparse processing element: merges a compressed IA fiber against N_K compressed
// weight fibers (CSR), one index comparison per cycle, with accumulate/ReLU/saturate.
module sparse_pe_mac #(
  parameter int N_K      = 8,
  parameter int IA_DEPTH = 32,
  parameter int W_DEPTH  = 256,
  parameter int C_W      = 5,
  parameter int IA_W     = 16,
  parameter int W_W      = 16,
  parameter int ACC_W    = 40,
  parameter int OUT_W    = 16
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic                                       i_start,
  input  logic                                       i_accum,
  input  logic                                       i_relu,
  input  logic [IA_W*IA_DEPTH-1:0]                   i_ia_data,
  input  logic [C_W*IA_DEPTH-1:0]                    i_ia_c_idx,
  input  logic [$clog2(IA_DEPTH):0]                  i_ia_len,
  input  logic [W_W*W_DEPTH-1:0]                     i_w_data,
  input  logic [C_W*W_DEPTH-1:0]                     i_w_c_idx,
  input  logic [($clog2(W_DEPTH)+1)*(N_K+1)-1:0]     i_pos_ptr,
  output logic                                       o_busy,
  output logic                                       o_finish,
  output logic [OUT_W*N_K-1:0]                       o_out,
  output logic [15:0]                                o_mac_cnt
);

  localparam int IA_AW = $clog2(IA_DEPTH);
  localparam int W_AW  = $clog2(W_DEPTH);
  localparam int LW    = IA_AW + 1;
  localparam int PW    = W_AW + 1;
  localparam int KW    = (N_K > 1) ? $clog2(N_K) : 1;
  localparam int PR_W  = IA_W + W_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MERGE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = ~OUT_MAX;

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v,
                                                       input logic relu);
    logic signed [ACC_W-1:0] x;
    x = (relu && v < 0) ? '0 : v;
    if (x > OUT_MAX)      return OUT_MAX[OUT_W-1:0];
    else if (x < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    else                  return x[OUT_W-1:0];
  endfunction

  logic [1:0]              state;
  logic [KW-1:0]           k;
  logic [LW-1:0]           i;
  logic [PW-1:0]           j;
  logic [15:0]             cnt;
  logic signed [ACC_W-1:0] acc [N_K];

  logic [C_W-1:0]          ia_c;
  logic [C_W-1:0]          w_c;
  logic signed [IA_W-1:0]  ia_d;
  logic signed [W_W-1:0]   w_d;
  logic signed [PR_W-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic [PW-1:0]           ptr0;
  logic [PW-1:0]           ptr_next;
  logic                    fiber_done;

  // Index truncation is harmless: out-of-range reads only happen when fiber_done masks them.
  always_comb begin
    ia_c       = i_ia_c_idx[i[IA_AW-1:0]*C_W +: C_W];
    ia_d       = i_ia_data[i[IA_AW-1:0]*IA_W +: IA_W];
    w_c        = i_w_c_idx[j[W_AW-1:0]*C_W +: C_W];
    w_d        = i_w_data[j[W_AW-1:0]*W_W +: W_W];
    prod       = ia_d * w_d;
    prod_ext   = {{(ACC_W-PR_W){prod[PR_W-1]}}, prod};
    ptr0       = i_pos_ptr[0 +: PW];
    ptr_next   = i_pos_ptr[(int'(k)+1)*PW +: PW];
    fiber_done = (i >= i_ia_len) || (j >= ptr_next);
  end

  assign o_busy   = (state != S_IDLE);
  assign o_finish = (state == S_DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      k         <= '0;
      i         <= '0;
      j         <= '0;
      cnt       <= '0;
      o_mac_cnt <= '0;
      o_out     <= '0;
      for (int n = 0; n < N_K; n++) acc[n] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            k   <= '0;
            i   <= '0;
            j   <= ptr0;
            cnt <= '0;
            if (!i_accum)
              for (int n = 0; n < N_K; n++) acc[n] <= '0;
            state <= S_MERGE;
          end
        end
        S_MERGE: begin
          if (fiber_done) begin
            // Results are registered on entry to DONE so o_out is valid with o_finish.
            if (k == KW'(N_K-1)) begin
              state     <= S_DONE;
              o_mac_cnt <= cnt;
              for (int n = 0; n < N_K; n++) o_out[n*OUT_W +: OUT_W] <= sat_out(acc[n], i_relu);
            end else begin
              k <= k + 1'b1;
              i <= '0;
              j <= ptr_next;
            end
          end else if (ia_c == w_c) begin
            acc[k] <= acc[k] + prod_ext;
            i      <= i + 1'b1;
            j      <= j + 1'b1;
            cnt    <= cnt + 1'b1;
          end else if (ia_c < w_c) begin
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sparse_pe_mac.sv
// Directed, table-driven bench for sparse_pe_mac with N_K=4.
module tb_sparse_pe_mac;
  localparam int N_K = 4, IA_DEPTH = 32, W_DEPTH = 256, C_W = 5;
  localparam int IA_W = 16, W_W = 16, ACC_W = 40, OUT_W = 16;
  localparam int LW = $clog2(IA_DEPTH) + 1, PW = $clog2(W_DEPTH) + 1;

  logic clk = 1'b0;
  logic rst, start, accum, relu;
  logic [IA_W*IA_DEPTH-1:0]   ia_data;
  logic [C_W*IA_DEPTH-1:0]    ia_c_idx;
  logic [LW-1:0]              ia_len;
  logic [W_W*W_DEPTH-1:0]     w_data;
  logic [C_W*W_DEPTH-1:0]     w_c_idx;
  logic [PW*(N_K+1)-1:0]      pos_ptr;
  logic                       busy, finish;
  logic [OUT_W*N_K-1:0]       out;
  logic [15:0]                mac_cnt;

  sparse_pe_mac #(.N_K(N_K), .IA_DEPTH(IA_DEPTH), .W_DEPTH(W_DEPTH), .C_W(C_W),
                  .IA_W(IA_W), .W_W(W_W), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_accum(accum), .i_relu(relu),
    .i_ia_data(ia_data), .i_ia_c_idx(ia_c_idx), .i_ia_len(ia_len),
    .i_w_data(w_data), .i_w_c_idx(w_c_idx), .i_pos_ptr(pos_ptr),
    .o_busy(busy), .o_finish(finish), .o_out(out), .o_mac_cnt(mac_cnt));

  always #5 clk = ~clk;

  typedef struct {
    int ia_len;
    int ia_c[4];
    int ia_d[4];
    int w_c[8];
    int w_d[8];
    int ptr[5];
    bit accum;
    bit relu;
    int exp_out[4];
    int exp_mac;
    int exp_lat;
  } vec_t;

  vec_t vt[10];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int out_k(input int kk);
    logic signed [OUT_W-1:0] s;
    s = out[kk*OUT_W +: OUT_W];
    return int'(s);
  endfunction

  task automatic load(input vec_t v);
    ia_data = '0; ia_c_idx = '0; w_data = '0; w_c_idx = '0; pos_ptr = '0;
    ia_len = v.ia_len[LW-1:0];
    for (int n = 0; n < 4; n++) begin
      ia_data[n*IA_W +: IA_W] = v.ia_d[n][IA_W-1:0];
      ia_c_idx[n*C_W +: C_W]  = v.ia_c[n][C_W-1:0];
    end
    for (int n = 0; n < 8; n++) begin
      w_data[n*W_W +: W_W]   = v.w_d[n][W_W-1:0];
      w_c_idx[n*C_W +: C_W]  = v.w_c[n][C_W-1:0];
    end
    for (int n = 0; n < 5; n++) pos_ptr[n*PW +: PW] = v.ptr[n][PW-1:0];
  endtask

  // lat counts edges from the start-sampling edge up to the one that raises o_finish.
  task automatic do_pass(input bit acc_i, input bit relu_i, input int glitch_at,
                         output int lat, output int busy1);
    @(negedge clk);
    accum = acc_i; relu = relu_i; start = 1'b1;
    lat = 0; busy1 = 0;
    do begin
      @(posedge clk);
      lat++;
      #1 start = (glitch_at > 0) && (lat == glitch_at || lat == glitch_at + 1);
      @(negedge clk);
      if (lat == 1) busy1 = int'(busy);
    end while (!finish && lat < 200);
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat, input int busy1);
    check({tag, " latency"}, lat, v.exp_lat);
    check({tag, " busy_after_start"}, busy1, 1);
    check({tag, " busy_in_done"}, int'(busy), 1);
    check({tag, " mac_cnt"}, int'(mac_cnt), v.exp_mac);
    for (int kk = 0; kk < N_K; kk++)
      check($sformatf("%s out[%0d]", tag, kk), out_k(kk), v.exp_out[kk]);
    @(negedge clk);
    check({tag, " finish_one_cycle"}, int'(finish), 0);
    check({tag, " out_held"}, out_k(0), v.exp_out[0]);
  endtask

  initial begin
    int lat, busy1, pulses;
    rst = 1'b1; start = 1'b0; accum = 1'b0; relu = 1'b0;
    ia_data = '0; ia_c_idx = '0; ia_len = '0; w_data = '0; w_c_idx = '0; pos_ptr = '0;

    // T1 empty
    vt[0] = '{ia_len:0, ia_c:'{0,0,0,0}, ia_d:'{0,0,0,0}, w_c:'{0,0,0,0,0,0,0,0},
              w_d:'{0,0,0,0,0,0,0,0}, ptr:'{0,0,0,0,0}, accum:0, relu:0,
              exp_out:'{0,0,0,0}, exp_mac:0, exp_lat:5};
    // T2 base merge
    vt[1] = '{ia_len:4, ia_c:'{2,3,5,6}, ia_d:'{2,3,5,6}, w_c:'{0,1,3,2,5,6,0,0},
              w_d:'{1,2,3,1,1,1,0,0}, ptr:'{0,3,6,6,6}, accum:0, relu:0,
              exp_out:'{9,13,0,0}, exp_mac:4, exp_lat:13};
    // T3 accumulate then clear
    vt[2] = vt[1]; vt[2].accum = 1; vt[2].exp_out = '{18,26,0,0};
    vt[3] = vt[1];
    // T4 sign, ReLU, saturation
    vt[4] = '{ia_len:1, ia_c:'{0,0,0,0}, ia_d:'{-3,0,0,0}, w_c:'{0,0,0,0,0,0,0,0},
              w_d:'{4,0,0,0,0,0,0,0}, ptr:'{0,1,1,1,1}, accum:0, relu:0,
              exp_out:'{-12,0,0,0}, exp_mac:1, exp_lat:6};
    vt[5] = vt[4]; vt[5].relu = 1; vt[5].exp_out = '{0,0,0,0};
    vt[6] = vt[4]; vt[6].ia_d = '{32767,0,0,0}; vt[6].w_d = '{32767,0,0,0,0,0,0,0};
    vt[6].exp_out = '{32767,0,0,0};
    vt[7] = vt[4]; vt[7].ia_d = '{-32768,0,0,0}; vt[7].w_d = '{32767,0,0,0,0,0,0,0};
    vt[7].exp_out = '{-32768,0,0,0};
    // no index matches
    vt[8] = '{ia_len:1, ia_c:'{1,0,0,0}, ia_d:'{5,0,0,0}, w_c:'{0,2,0,0,0,0,0,0},
              w_d:'{7,7,0,0,0,0,0,0}, ptr:'{0,2,2,2,2}, accum:0, relu:0,
              exp_out:'{0,0,0,0}, exp_mac:0, exp_lat:7};
    // only the last lane has work
    vt[9] = '{ia_len:1, ia_c:'{4,0,0,0}, ia_d:'{7,0,0,0}, w_c:'{4,0,0,0,0,0,0,0},
              w_d:'{-2,0,0,0,0,0,0,0}, ptr:'{0,0,0,0,1}, accum:0, relu:0,
              exp_out:'{0,0,0,-14}, exp_mac:1, exp_lat:6};

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    check("reset busy", int'(busy), 0);
    check("reset finish", int'(finish), 0);
    check("reset mac_cnt", int'(mac_cnt), 0);
    for (int kk = 0; kk < N_K; kk++) check($sformatf("reset out[%0d]", kk), out_k(kk), 0);

    for (int n = 0; n < 10; n++) begin
      load(vt[n]);
      do_pass(vt[n].accum, vt[n].relu, 0, lat, busy1);
      check_result($sformatf("v%0d", n), vt[n], lat, busy1);
    end

    // T5: start pulses mid-pass must be ignored
    load(vt[1]);
    do_pass(1'b0, 1'b0, 3, lat, busy1);
    check_result("t5", vt[1], lat, busy1);
    pulses = 0;
    repeat (20) begin @(negedge clk); if (finish) pulses++; end
    check("t5 extra_finish", pulses, 0);

    // T6: reset mid-pass
    load(vt[1]);
    @(negedge clk); accum = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6 busy", int'(busy), 0);
    check("t6 mac_cnt", int'(mac_cnt), 0);
    for (int kk = 0; kk < N_K; kk++) check($sformatf("t6 out[%0d]", kk), out_k(kk), 0);
    pulses = 0;
    repeat (20) begin @(negedge clk); if (finish) pulses++; end
    check("t6 no_finish", pulses, 0);
    // accum=1 after reset still yields the base result because reset cleared the accumulators
    do_pass(1'b1, 1'b0, 0, lat, busy1);
    check_result("t6 restart", vt[1], lat, busy1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
